// File: rtl/alpha_blend_pkg.sv
// Shared types and constants for the alpha blend sequencer.
// Contents:
//   state_t      - sequencer FSM states
//   ALPHA_MAX    - largest legal alpha weight (tenths)
//   COLOR_W      - colour channel width
//   clamp_alpha  - saturates an incoming alpha weight to ALPHA_MAX
package alpha_blend_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      BLEND   = 3'd2,
      RELEASE = 3'd3,
      WRITE   = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam logic [3:0] ALPHA_MAX = 4'd10;
   localparam int         COLOR_W   = 8;

   function automatic logic [3:0] clamp_alpha(input logic [3:0] a);
      return (a > ALPHA_MAX) ? ALPHA_MAX : a;
   endfunction

endpackage

// File: rtl/alpha_blend_sequencer.sv
// Initiator side of the pixel_ready/pixel_done blend handshake.
// Walks a run of pixel addresses: reads the fg/bg pair, hands it to the
// blender, waits for pixel_done, captures alpha_result and writes it back.
// Only one blend is ever in flight.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start/start_addr/pixel_count/alpha_in   run launch (sampled in IDLE)
//   rd_req/rd_addr/rd_ack/rd_fg/rd_bg       layer memory read port
//   pixel_ready/color1/color2/alpha_value   operands to the blender
//   pixel_done/alpha_result                 response from the blender
//   wr_req/wr_addr/wr_data/wr_ack           frame buffer write port
//   busy/done/error                         run status
// Every output is a register updated together with the state, so request
// lines are already high in the first cycle of their state.
module alpha_blend_sequencer
   import alpha_blend_pkg::*;
#(
   parameter int ADDR_W        = 16,
   parameter int BLEND_TIMEOUT = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ADDR_W-1:0]  start_addr,
   input  logic [ADDR_W-1:0]  pixel_count,
   input  logic [3:0]         alpha_in,
   output logic               rd_req,
   output logic [ADDR_W-1:0]  rd_addr,
   input  logic               rd_ack,
   input  logic [COLOR_W-1:0] rd_fg,
   input  logic [COLOR_W-1:0] rd_bg,
   output logic               pixel_ready,
   output logic [COLOR_W-1:0] color1,
   output logic [COLOR_W-1:0] color2,
   output logic [3:0]         alpha_value,
   input  logic               pixel_done,
   input  logic [COLOR_W-1:0] alpha_result,
   output logic               wr_req,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [COLOR_W-1:0] wr_data,
   input  logic               wr_ack,
   output logic               busy,
   output logic               done,
   output logic               error
);

   localparam int TMO_W = (BLEND_TIMEOUT > 2) ? $clog2(BLEND_TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BLEND_TIMEOUT - 1);

   state_t            state_r;
   logic [ADDR_W-1:0] cur_addr_r;
   logic [ADDR_W-1:0] remaining_r;
   logic [TMO_W-1:0]  tmo_r;

   // Sequencer FSM: state, run bookkeeping and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         cur_addr_r  <= '0;
         remaining_r <= '0;
         tmo_r       <= '0;
         rd_req      <= 1'b0;
         rd_addr     <= '0;
         pixel_ready <= 1'b0;
         color1      <= '0;
         color2      <= '0;
         alpha_value <= 4'd0;
         wr_req      <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  cur_addr_r  <= start_addr;
                  remaining_r <= pixel_count;
                  alpha_value <= clamp_alpha(alpha_in);
                  error       <= 1'b0;
                  busy        <= 1'b1;
                  if (pixel_count == '0) begin
                     state_r <= DONE;
                  end else begin
                     rd_req  <= 1'b1;
                     rd_addr <= start_addr;
                     state_r <= READ;
                  end
               end
            end
            READ: begin
               if (rd_ack) begin
                  color1      <= rd_fg;
                  color2      <= rd_bg;
                  rd_req      <= 1'b0;
                  pixel_ready <= 1'b1;
                  tmo_r       <= '0;
                  state_r     <= BLEND;
               end
            end
            BLEND: begin
               if (pixel_done) begin
                  wr_data     <= alpha_result;
                  pixel_ready <= 1'b0;
                  state_r     <= RELEASE;
               end else if (tmo_r == TMO_LAST) begin
                  // Blender never answered: abandon the rest of the run.
                  error       <= 1'b1;
                  pixel_ready <= 1'b0;
                  state_r     <= DONE;
               end else begin
                  tmo_r <= tmo_r + TMO_W'(1);
               end
            end
            RELEASE: begin
               // Wait for the blender to re-arm before touching the next pixel.
               if (!pixel_done) begin
                  wr_req  <= 1'b1;
                  wr_addr <= cur_addr_r;
                  state_r <= WRITE;
               end
            end
            WRITE: begin
               if (wr_ack) begin
                  wr_req <= 1'b0;
                  if (remaining_r == ADDR_W'(1)) begin
                     state_r <= DONE;
                  end else begin
                     cur_addr_r  <= cur_addr_r + ADDR_W'(1);
                     remaining_r <= remaining_r - ADDR_W'(1);
                     rd_req      <= 1'b1;
                     rd_addr     <= cur_addr_r + ADDR_W'(1);
                     state_r     <= READ;
                  end
               end
            end
            DONE: begin
               // busy stays high through DONE and drops as done pulses.
               done    <= 1'b1;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               rd_req      <= 1'b0;
               pixel_ready <= 1'b0;
               wr_req      <= 1'b0;
               busy        <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

endmodule
